mem_read_arbiter: RTL

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// Two-master AXI read arbiter (m0 = icache, m1 = LSU) with one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives m0 fixed priority.
module mem_read_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             m0_arvalid,
   output logic             m0_arready,
   input  logic [WIDTH-1:0] m0_araddr,
   input  logic [7:0]       m0_arlen,
   input  logic [2:0]       m0_arsize,
   input  logic [1:0]       m0_arburst,
   input  logic             m1_arvalid,
   output logic             m1_arready,
   input  logic [WIDTH-1:0] m1_araddr,
   input  logic [7:0]       m1_arlen,
   input  logic [2:0]       m1_arsize,
   input  logic [1:0]       m1_arburst,
   output logic             m0_rvalid,
   input  logic             m0_rready,
   output logic             m1_rvalid,
   input  logic             m1_rready,
   output logic [WIDTH-1:0] m_rdata,
   output logic [1:0]       m_rresp,
   output logic             m_rlast,
   output logic             s_arvalid,
   input  logic             s_arready,
   output logic [WIDTH-1:0] s_araddr,
   output logic [7:0]       s_arlen,
   output logic [2:0]       s_arsize,
   output logic [1:0]       s_arburst,
   input  logic             s_rvalid,
   input  logic [WIDTH-1:0] s_rdata,
   input  logic [1:0]       s_rresp,
   input  logic             s_rlast,
   output logic             s_rready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;   // 0 = m0, 1 = m1
`ifdef ARB_ROUND_ROBIN_EN
   logic   last_grant_q, last_grant_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      s_arvalid    = 1'b0;
      m0_arready   = 1'b0;
      m1_arready   = 1'b0;
      m0_rvalid    = 1'b0;
      m1_rvalid    = 1'b0;
      s_rready     = 1'b0;
      // Payload mux follows the latched grant so it cannot move while ADDR stalls
      s_araddr     = grant_q ? m1_araddr  : m0_araddr;
      s_arlen      = grant_q ? m1_arlen   : m0_arlen;
      s_arsize     = grant_q ? m1_arsize  : m0_arsize;
      s_arburst    = grant_q ? m1_arburst : m0_arburst;
      m_rdata      = s_rdata;
      m_rresp      = s_rresp;
      m_rlast      = s_rlast;

      unique case (state_q)
         IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               if (m0_arvalid && m1_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
                  grant_d = ~last_grant_q;
`else
                  grant_d = 1'b0;
`endif
               end else begin
                  grant_d = m1_arvalid;
               end
               state_d = ADDR;
            end
         end
         ADDR: begin
            s_arvalid  = 1'b1;
            m0_arready = ~grant_q & s_arready;
            m1_arready =  grant_q & s_arready;
            if (s_arready) state_d = DATA;
         end
         DATA: begin
            m0_rvalid = ~grant_q & s_rvalid;
            m1_rvalid =  grant_q & s_rvalid;
            s_rready  = grant_q ? m1_rready : m0_rready;
            // Only rlast ends the burst; error responses pass through untouched
            if (s_rvalid && s_rready && s_rlast) begin
               state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = grant_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
